timer_entry_register: RTL and testbench

Debounced digit-entry register for the microwave timer input path, directly downstream of the keypad encoder. It synchronises the encoder's 4-bit key code and active-low key-present strobe, accepts one digit per debounced keypress, and shifts it into a 4-digit BCD MM:SS entry. On a validated start request it hands the entry to the countdown timer with a one-cycle load pulse.

---
 rtl/timer_entry_pkg.sv | 26 ++
 rtl/key_debouncer.sv | 127 ++++++++++++
 rtl/timer_entry_register.sv | 118 +++++++++++
 tb/tb_timer_entry_register.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_entry_pkg.sv
// ============================================================================
// Module   : timer_entry_pkg
// Purpose  : Shared types and constants for the microwave timer entry path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package timer_entry_pkg;

    localparam int BCD_W        = 4;
    localparam int NUM_DIGITS   = 4;
    localparam int MAX_SEC_TENS = 5;
    localparam int MAX_DIGIT    = 9;
    localparam int DIG_CNT_W    = 3;
    localparam int DEB_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// Module   : key_debouncer
// Purpose  : Synchronises the keypad strobe/code and emits one accept strobe
//            per debounced press.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debouncer
    import timer_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_loadn,
    input  logic [BCD_W-1:0] i_code,
    input  logic             i_clear,
    output logic             o_press_accept,
    output logic [BCD_W-1:0] o_code
);

    localparam logic [DEB_CNT_W:0] C_N = (DEB_CNT_W+1)'(DEBOUNCE_CYCLES);

    logic                 r_loadn_s1;
    logic                 r_loadn_s2;
    logic [BCD_W-1:0]     r_code_s1;
    logic [BCD_W-1:0]     r_code_s2;
    key_state_t           r_state;
    logic [DEB_CNT_W-1:0] r_cnt;

    key_state_t           w_state_nxt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic [DEB_CNT_W:0]   w_cnt_inc;
    logic                 w_accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_loadn_s1 <= 1'b1;
            r_loadn_s2 <= 1'b1;
            r_code_s1  <= '1;
            r_code_s2  <= '1;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else begin
            r_loadn_s1 <= i_loadn;
            r_loadn_s2 <= r_loadn_s1;
            r_code_s1  <= i_code;
            r_code_s2  <= r_code_s1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    // The entry transition (IDLE->PRESS, HELD->RELEASE) already counts one
    // sample, so a single-sample debounce completes on that transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_loadn_s2) begin
                        if (C_N == 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = PRESS;
                            w_cnt_nxt   = DEB_CNT_W'(1);
                        end
                    end
                end
                PRESS: begin
                    if (r_loadn_s2) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == C_N) begin
                        w_accept    = 1'b1;
                        w_state_nxt = HELD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc[DEB_CNT_W-1:0];
                    end
                end
                HELD: begin
                    if (r_loadn_s2) begin
                        if (C_N == 1) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_cnt_nxt   = DEB_CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (!r_loadn_s2) begin
                        w_state_nxt = HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == C_N) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc[DEB_CNT_W-1:0];
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_press_accept = w_accept;
    assign o_code         = r_code_s2;

endmodule

`default_nettype wire

// File: rtl/timer_entry_register.sv
// ============================================================================
// Module   : timer_entry_register
// Purpose  : 4-digit BCD MM:SS entry register with validated timer load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_entry_register
    import timer_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [BCD_W-1:0]            saida_cod,
    input  logic                        loadn,
    input  logic                        clearn,
    input  logic                        startn,
    input  logic                        running,
    output logic [BCD_W*NUM_DIGITS-1:0] digitos,
    output logic                        timer_load,
    output logic                        entry_valid
);

    localparam int DIG_W = BCD_W * NUM_DIGITS;

    logic                 r_startn_s1;
    logic                 r_startn_s2;
    logic                 r_startn_s3;
    logic                 r_clearn_s1;
    logic                 r_clearn_s2;
    logic [DIG_W-1:0]     r_digitos;
    logic [DIG_CNT_W-1:0] r_count;
    logic                 r_timer_load;
    logic                 r_entry_valid;

    logic                 w_press;
    logic [BCD_W-1:0]     w_code;
    logic                 w_clear;
    logic                 w_start_edge;
    logic                 w_start_ok;
    logic                 w_shift_ok;
    logic [BCD_W-1:0]     w_sec_tens;
    logic [DIG_W-1:0]     w_dig_nxt;
    logic [DIG_CNT_W-1:0] w_cnt_nxt;
    logic                 w_load_nxt;
    logic                 w_valid_nxt;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk            (clk),
        .resetn         (resetn),
        .i_loadn        (loadn),
        .i_code         (saida_cod),
        .i_clear        (w_clear),
        .o_press_accept (w_press),
        .o_code         (w_code)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_startn_s1   <= 1'b1;
            r_startn_s2   <= 1'b1;
            r_startn_s3   <= 1'b1;
            r_clearn_s1   <= 1'b1;
            r_clearn_s2   <= 1'b1;
            r_digitos     <= '0;
            r_count       <= '0;
            r_timer_load  <= 1'b0;
            r_entry_valid <= 1'b0;
        end else begin
            r_startn_s1   <= startn;
            r_startn_s2   <= r_startn_s1;
            r_startn_s3   <= r_startn_s2;
            r_clearn_s1   <= clearn;
            r_clearn_s2   <= r_clearn_s1;
            r_digitos     <= w_dig_nxt;
            r_count       <= w_cnt_nxt;
            r_timer_load  <= w_load_nxt;
            r_entry_valid <= w_valid_nxt;
        end
    end

    assign w_clear      = !r_clearn_s2;
    assign w_start_edge = !r_startn_s2 && r_startn_s3;
    assign w_sec_tens   = r_digitos[2*BCD_W-1:BCD_W];
    assign w_start_ok   = w_start_edge && !running && r_entry_valid &&
                          (w_sec_tens <= BCD_W'(MAX_SEC_TENS));
    assign w_shift_ok   = w_press && !running &&
                          (r_count != DIG_CNT_W'(NUM_DIGITS)) &&
                          (w_code <= BCD_W'(MAX_DIGIT));

    // Clear beats start beats shift; a load uses the pre-shift entry.
    always_comb begin
        w_dig_nxt  = r_digitos;
        w_cnt_nxt  = r_count;
        w_load_nxt = 1'b0;
        if (w_clear) begin
            w_dig_nxt = '0;
            w_cnt_nxt = '0;
        end else if (w_start_ok) begin
            w_load_nxt = 1'b1;
        end else if (w_shift_ok) begin
            w_dig_nxt = {r_digitos[BCD_W*(NUM_DIGITS-1)-1:0], w_code};
            w_cnt_nxt = r_count + 1'b1;
        end
    end

    assign w_valid_nxt = (w_cnt_nxt != '0) && (w_dig_nxt != '0);

    assign digitos     = r_digitos;
    assign timer_load  = r_timer_load;
    assign entry_valid = r_entry_valid;

endmodule

`default_nettype wire

// File: tb/tb_timer_entry_register.sv
// ============================================================================
// Module   : tb_timer_entry_register
// Purpose  : Scoreboard bench for timer_entry_register with directed presses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timer_entry_register;

    logic        clk;
    logic        resetn;
    logic [3:0]  saida_cod;
    logic        loadn;
    logic        clearn;
    logic        startn;
    logic        running;
    logic [15:0] digitos;
    logic        timer_load;
    logic        entry_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_load;
        logic [15:0] dig;
        logic        ev;
        int          at;
    } exp_t;

    exp_t q[$];

    timer_entry_register #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .saida_cod   (saida_cod),
        .loadn       (loadn),
        .clearn      (clearn),
        .startn      (startn),
        .running     (running),
        .digitos     (digitos),
        .timer_load  (timer_load),
        .entry_valid (entry_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Monitor: every visible output event pops one expectation.
    initial begin
        logic [15:0] prev_d;
        logic        prev_v;
        logic        prev_l;
        exp_t        e;
        prev_d = '0;
        prev_v = 1'b0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_d = digitos;
                prev_v = entry_valid;
                prev_l = timer_load;
            end else begin
                if (timer_load) begin
                    if (q.size() == 0) begin
                        check("unexpected_load", 1'b0,
                              $sformatf("got load dig=%h at cyc %0d, expected none", digitos, cyc));
                    end else begin
                        e = q.pop_front();
                        check("load", e.is_load && !prev_l && digitos == e.dig && cyc == e.at,
                              $sformatf("got load dig=%h cyc=%0d prev_load=%0b, expected load=%0b dig=%h cyc=%0d",
                                        digitos, cyc, prev_l, e.is_load, e.dig, e.at));
                    end
                end
                if (digitos != prev_d || entry_valid != prev_v) begin
                    if (q.size() == 0) begin
                        check("unexpected_change", 1'b0,
                              $sformatf("got dig=%h ev=%0b at cyc %0d, expected no change", digitos, entry_valid, cyc));
                    end else begin
                        e = q.pop_front();
                        check("entry", !e.is_load && digitos == e.dig && entry_valid == e.ev && cyc == e.at,
                              $sformatf("got dig=%h ev=%0b cyc=%0d, expected load=%0b dig=%h ev=%0b cyc=%0d",
                                        digitos, entry_valid, cyc, e.is_load, e.dig, e.ev, e.at));
                    end
                end
                prev_d = digitos;
                prev_v = entry_valid;
                prev_l = timer_load;
            end
        end
    end

    task automatic push(input bit is_load, input logic [15:0] dig, input logic ev, input int at);
        exp_t e;
        e.is_load = is_load;
        e.dig     = dig;
        e.ev      = ev;
        e.at      = at;
        q.push_back(e);
    endtask

    // Clean press: digit appears on the 6th edge after raw loadn is sampled low.
    task automatic press(input logic [3:0] code, input bit expect_it, input logic [15:0] dig);
        @(negedge clk);
        saida_cod = code;
        loadn     = 1'b0;
        if (expect_it) push(1'b0, dig, 1'b1, cyc + 6);
        repeat (8) @(negedge clk);
        loadn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_pulse(input bit expect_it);
        @(negedge clk);
        clearn = 1'b0;
        if (expect_it) push(1'b0, 16'h0000, 1'b0, cyc + 3);
        @(negedge clk);
        clearn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic start_req(input bit expect_it, input logic [15:0] dig);
        @(negedge clk);
        startn = 1'b0;
        if (expect_it) push(1'b1, dig, 1'b1, cyc + 3);
        repeat (10) @(negedge clk);
        startn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size() == 0, $sformatf("got %0d pending, expected 0", q.size()));
    endtask

    initial begin
        resetn    = 1'b0;
        saida_cod = 4'd0;
        loadn     = 1'b1;
        clearn    = 1'b1;
        startn    = 1'b1;
        running   = 1'b0;
        #1;
        check("rst_digitos", digitos == 16'h0000, $sformatf("got %h, expected 0000", digitos));
        check("rst_load", timer_load == 1'b0, $sformatf("got %0b, expected 0", timer_load));
        check("rst_valid", entry_valid == 1'b0, $sformatf("got %0b, expected 0", entry_valid));
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Keys 1,2,3,0
        press(4'd1, 1'b1, 16'h0001);
        press(4'd2, 1'b1, 16'h0012);
        press(4'd3, 1'b1, 16'h0123);
        press(4'd0, 1'b1, 16'h1230);
        clear_pulse(1'b1);

        // Bounce: low 3, high 1, low 6 -> one digit after the 6-sample run
        begin
            int c0;
            @(negedge clk);
            saida_cod = 4'd5;
            loadn     = 1'b0;
            c0        = cyc;
            repeat (3) @(negedge clk);
            loadn = 1'b1;
            @(negedge clk);
            loadn = 1'b0;
            push(1'b0, 16'h0005, 1'b1, c0 + 10);
            repeat (6) @(negedge clk);
            loadn = 1'b1;
            repeat (12) @(negedge clk);
        end
        clear_pulse(1'b1);

        // Five digits, the fifth is dropped
        press(4'd9, 1'b1, 16'h0009);
        press(4'd8, 1'b1, 16'h0098);
        press(4'd7, 1'b1, 16'h0987);
        press(4'd6, 1'b1, 16'h9876);
        press(4'd5, 1'b0, 16'h0000);
        clear_pulse(1'b1);

        // 01:30 loads, 01:70 is rejected
        press(4'd0, 1'b0, 16'h0000);
        press(4'd1, 1'b1, 16'h0001);
        press(4'd3, 1'b1, 16'h0013);
        press(4'd0, 1'b1, 16'h0130);
        start_req(1'b1, 16'h0130);
        clear_pulse(1'b1);
        press(4'd0, 1'b0, 16'h0000);
        press(4'd1, 1'b1, 16'h0001);
        press(4'd7, 1'b1, 16'h0017);
        press(4'd0, 1'b1, 16'h0170);
        start_req(1'b0, 16'h0000);
        clear_pulse(1'b1);

        // Entry locked while running; clear still works
        press(4'd3, 1'b1, 16'h0003);
        running = 1'b1;
        press(4'd4, 1'b0, 16'h0000);
        start_req(1'b0, 16'h0000);
        clear_pulse(1'b1);
        running = 1'b0;

        // Reset during PRESS with a start edge pending
        press(4'd7, 1'b1, 16'h0007);
        drain();
        @(negedge clk);
        saida_cod = 4'd2;
        loadn     = 1'b0;
        repeat (2) @(negedge clk);
        startn = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_digitos", digitos == 16'h0000, $sformatf("got %h, expected 0000", digitos));
        check("midrst_load", timer_load == 1'b0, $sformatf("got %0b, expected 0", timer_load));
        check("midrst_valid", entry_valid == 1'b0, $sformatf("got %0b, expected 0", entry_valid));
        repeat (2) @(negedge clk);
        loadn  = 1'b1;
        startn = 1'b1;
        #2;
        resetn = 1'b1;
        repeat (20) @(negedge clk);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
